mipi_rx_pkt_assembler: RTL and testbench
========================================

MIPI_RX_PKT_ASSEMBLER -- requirements
Module: mipi_rx_pkt_assembler

Interface
REQ-001 SHALL have parameter DLEN, default 48, payload length in bytes; DLEN % BPW = 0, otherwise elaboration fails.
REQ-002 SHALL have parameter BPW, default 6, bytes used per 64-bit beat, range 1..8; bytes are taken from in_data[BPW*8-1:0].
REQ-003 SHALL have parameter SYNC, default 8'h7E, the header byte value.
REQ-004 SHALL have parameter TIMEOUT, default 1024, the maximum idle cycles between beats while collecting.
REQ-005 Ports: rx_pixel_clk, in, 1, sole clock; all logic on its rising edge.
REQ-006 Ports: rst, in, 1, reset, asynchronous, active-high.
REQ-007 Ports: in_valid, in, 1, beat strobe from the MIPI RX VALID output.
REQ-008 Ports: in_data, in, 64, beat data.
REQ-009 Ports: in_vc, in, 2, virtual channel of the beat.
REQ-010 Ports: vc_ena, in, 4, per-VC accept mask.
REQ-011 Ports: out_data, out, DLEN*8, assembled payload.
REQ-012 Ports: out_vc, out, 2, VC of the payload.
REQ-013 Ports: out_valid, out, 1, payload ready; out_ready, in, 1, consumer accept.
REQ-014 Ports: busy, out, 1, high in COLLECT, CHECK or HOLD.
REQ-015 Ports: ok_cnt, err_cnt and drop_cnt, out, 16 each, statistics counters.

Function
REQ-016 A beat SHALL be accepted only when in_valid=1 and vc_ena[in_vc]=1; other cycles are ignored.
REQ-017 Beat byte order SHALL be most significant byte first: byte BPW-1 first, byte 0 last.
REQ-018 FSM states SHALL be HUNT, COLLECT, CHECK, HOLD.
REQ-019 HUNT: an accepted beat whose BPW bytes all equal SYNC SHALL be a header; FSM -> COLLECT and locks lock_vc=in_vc.
REQ-020 COLLECT: beats from lock_vc SHALL shift into the buffer (buf = buf<<(BPW*8) | beat) and update an 8-bit mod-256 byte sum; beats from other VCs are ignored.
REQ-021 After DLEN/BPW payload beats the FSM SHALL move to CHECK; the next lock_vc beat is the trailer.
REQ-022 CHECK: if trailer byte BPW-1 equals the sum, FSM SHALL go to HOLD, out_valid=1 the next cycle, ok_cnt+1; otherwise FSM -> HUNT, err_cnt+1, out_valid stays 0.
REQ-023 Trailer bytes other than byte BPW-1 SHALL be ignored.
REQ-024 First payload byte SHALL appear at out_data[DLEN*8-1 -: 8].
REQ-025 A header in COLLECT or CHECK SHALL be treated as data, with no resync.
REQ-026 Timeout: in COLLECT/CHECK, TIMEOUT consecutive cycles without an accepted lock_vc beat SHALL abort to HUNT with err_cnt+1.
REQ-027 HOLD: out_data and out_vc SHALL be stable while out_valid=1; out_valid drops only after a cycle with out_valid&out_ready.
REQ-028 HOLD: accepted beats SHALL be discarded, and each header seen increments drop_cnt.
REQ-029 Handshake completion and a header in the same cycle SHALL drop nothing; the header is taken, FSM -> COLLECT.
REQ-030 All counters SHALL saturate at 16'hFFFF.

Reset
REQ-031 rst=1 SHALL force state HUNT, out_valid=0, out_data=0, out_vc=0, busy=0, sum=0, beat count=0, timeout count=0 and all statistics counters=0.
REQ-032 Reset mid-packet or during HOLD SHALL discard the packet with no counter update; the first accepted beat after release is evaluated in HUNT.

Structure
REQ-033 Package mipi_rx_pkg SHALL hold the state enum, default SYNC 8'h7E, and counter width 16.
REQ-034 One sub-module, sat_counter (16-bit saturating increment), SHALL be instantiated three times.

Verification (DLEN=12, BPW=6, vc_ena=4'b0001)
REQ-035 Beats 0x7E7E7E7E7E7E, 0x010203040506, 0x0708090A0B0C, 0x4E0000000000 on VC0 SHALL give, one cycle after the trailer, out_valid=1, out_data=0x0102030405060708090A0B0C, out_vc=0 and ok_cnt=1.
REQ-036 The same packet with trailer 0x4F0000000000 SHALL give out_valid=0, err_cnt=1, FSM HUNT.
REQ-037 With out_ready=0 after a good packet, a second header SHALL give drop_cnt=1 and out_data unchanged; asserting out_ready with a header in the same cycle SHALL take the header.
REQ-038 A header followed by one payload beat then TIMEOUT idle cycles SHALL give err_cnt=1 and busy=0.
REQ-039 A header on VC1 with vc_ena=4'b0001 SHALL be ignored; VC1 beats interleaved in a VC0 packet SHALL not alter out_data or the sum.
REQ-040 rst pulsed after the second payload beat SHALL clear all outputs and counters, and a full packet afterwards SHALL give ok_cnt=1.

Source files
------------

// File: rtl/mipi_rx_pkg.sv
// Shared types and constants for the MIPI RX packet assembler.
package mipi_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2,
    ST_HOLD    = 2'd3
  } rx_state_e;

  localparam logic [7:0] SYNC_DEF = 8'h7E;
  localparam int         CNT_W    = 16;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter: increments on inc and sticks at all-ones.
module sat_counter
  import mipi_rx_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up, holding at the maximum value instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/mipi_rx_pkt_assembler.sv
// Assembles fixed-length payloads framed by a SYNC header beat and a
// byte-sum trailer from the MIPI RX beat stream, one virtual channel at a time.
module mipi_rx_pkt_assembler
  import mipi_rx_pkg::*;
#(
  parameter int         DLEN    = 48,
  parameter int         BPW     = 6,
  parameter logic [7:0] SYNC    = SYNC_DEF,
  parameter int         TIMEOUT = 1024
) (
  input  logic              rx_pixel_clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [63:0]       in_data,
  input  logic [1:0]        in_vc,
  input  logic [3:0]        vc_ena,
  output logic [DLEN*8-1:0] out_data,
  output logic [1:0]        out_vc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  ok_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int NBEATS = DLEN / BPW;
  localparam int BCW    = $clog2(NBEATS + 1);
  localparam int TCW    = $clog2(TIMEOUT + 1);

  if (BPW < 1 || BPW > 8 || DLEN < BPW || (DLEN % BPW) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("mipi_rx_pkt_assembler: DLEN must be a nonzero multiple of BPW (1..8), TIMEOUT >= 1");
  end

  rx_state_e         state, nxt;
  logic [DLEN*8-1:0] pay_buf;
  logic [7:0]        sum, beat_sum;
  logic [BCW-1:0]    beat_cnt;
  logic [TCW-1:0]    tmo_cnt;
  logic [1:0]        lock_vc;

  logic accept, is_hdr, hdr_acc, lock_hit, last_beat, trl_ok, tmo_exp;
  logic hdr_take, shift, tmo_run, ld_out, ok_inc, err_inc, drop_inc;
  logic unused_hi;

  // Bytes above BPW never carry data.
  assign unused_hi = ^(in_data >> (BPW*8));

  // Per-beat byte analysis: header pattern and mod-256 byte sum.
  always_comb begin
    is_hdr   = 1'b1;
    beat_sum = '0;
    for (int i = 0; i < BPW; i++) begin
      if (in_data[i*8 +: 8] != SYNC) is_hdr = 1'b0;
      beat_sum = beat_sum + in_data[i*8 +: 8];
    end
  end

  assign accept    = in_valid & vc_ena[in_vc];
  assign hdr_acc   = accept & is_hdr;
  assign lock_hit  = accept && (in_vc == lock_vc);
  assign last_beat = (beat_cnt == BCW'(NBEATS - 1));
  assign trl_ok    = (in_data[BPW*8-1 -: 8] == sum);
  assign tmo_exp   = (tmo_cnt == TCW'(TIMEOUT - 1));

  assign busy      = (state != ST_HUNT);
  assign out_valid = (state == ST_HOLD);

  // State register.
  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) state <= ST_HUNT;
    else     state <= nxt;
  end

  // Next-state decode and datapath/counter strobes.
  always_comb begin
    nxt      = state;
    hdr_take = 1'b0;
    shift    = 1'b0;
    tmo_run  = 1'b0;
    ld_out   = 1'b0;
    ok_inc   = 1'b0;
    err_inc  = 1'b0;
    drop_inc = 1'b0;
    case (state)
      ST_HUNT: begin
        if (hdr_acc) begin
          nxt      = ST_COLLECT;
          hdr_take = 1'b1;
        end
      end
      ST_COLLECT: begin
        tmo_run = 1'b1;
        if (lock_hit) begin
          shift = 1'b1;
          if (last_beat) nxt = ST_CHECK;
        end else if (tmo_exp) begin
          nxt     = ST_HUNT;
          err_inc = 1'b1;
        end
      end
      ST_CHECK: begin
        // Any beat from the locked VC is the trailer, even if it looks like a header.
        tmo_run = 1'b1;
        if (lock_hit) begin
          if (trl_ok) begin
            nxt    = ST_HOLD;
            ld_out = 1'b1;
            ok_inc = 1'b1;
          end else begin
            nxt     = ST_HUNT;
            err_inc = 1'b1;
          end
        end else if (tmo_exp) begin
          nxt     = ST_HUNT;
          err_inc = 1'b1;
        end
      end
      ST_HOLD: begin
        // A header arriving with the handshake starts the next packet instead of being dropped.
        if (out_ready) begin
          if (hdr_acc) begin
            nxt      = ST_COLLECT;
            hdr_take = 1'b1;
          end else begin
            nxt = ST_HUNT;
          end
        end else if (hdr_acc) begin
          drop_inc = 1'b1;
        end
      end
      default: nxt = ST_HUNT;
    endcase
  end

  // Payload shift buffer, running sum, beat and idle counters, VC lock.
  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) begin
      pay_buf  <= '0;
      sum      <= '0;
      beat_cnt <= '0;
      tmo_cnt  <= '0;
      lock_vc  <= '0;
    end else begin
      if (hdr_take) begin
        lock_vc  <= in_vc;
        sum      <= '0;
        beat_cnt <= '0;
        tmo_cnt  <= '0;
      end else begin
        if (shift) begin
          pay_buf  <= (pay_buf << (BPW*8)) | (DLEN*8)'(in_data[BPW*8-1:0]);
          sum      <= sum + beat_sum;
          beat_cnt <= beat_cnt + BCW'(1);
        end
        if (tmo_run) tmo_cnt <= lock_hit ? '0 : tmo_cnt + TCW'(1);
      end
    end
  end

  // Output payload register, loaded only when a trailer checks good.
  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_vc   <= '0;
    end else if (ld_out) begin
      out_data <= pay_buf;
      out_vc   <= lock_vc;
    end
  end

  sat_counter #(.W(CNT_W)) u_ok_cnt   (.clk(rx_pixel_clk), .rst(rst), .inc(ok_inc),   .cnt(ok_cnt));
  sat_counter #(.W(CNT_W)) u_err_cnt  (.clk(rx_pixel_clk), .rst(rst), .inc(err_inc),  .cnt(err_cnt));
  sat_counter #(.W(CNT_W)) u_drop_cnt (.clk(rx_pixel_clk), .rst(rst), .inc(drop_inc), .cnt(drop_cnt));

endmodule

// File: tb/tb_mipi_rx_pkt_assembler.sv
// Self-checking bench: directed packet scenarios plus randomized traffic,
// every cycle compared against a queue-based packet model.
module tb_mipi_rx_pkt_assembler;

  localparam int         DLEN    = 12;
  localparam int         BPW     = 6;
  localparam int         TIMEOUT = 20;
  localparam int         NB      = DLEN / BPW;
  localparam logic [7:0] SYNC    = 8'h7E;

  localparam logic [63:0] HDR     = 64'h0000_7E7E_7E7E_7E7E;
  localparam logic [63:0] P1      = 64'h0000_0102_0304_0506;
  localparam logic [63:0] P2      = 64'h0000_0708_090A_0B0C;
  localparam logic [63:0] TRL_OK  = 64'h0000_4E00_0000_0000;
  localparam logic [63:0] TRL_BAD = 64'h0000_4F00_0000_0000;
  localparam logic [95:0] PAY     = 96'h0102_0304_0506_0708_090A_0B0C;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [63:0]       in_data;
  logic [1:0]        in_vc;
  logic [3:0]        vc_ena;
  logic [DLEN*8-1:0] out_data;
  logic [1:0]        out_vc;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic [15:0]       ok_cnt, err_cnt, drop_cnt;

  mipi_rx_pkt_assembler #(.DLEN(DLEN), .BPW(BPW), .SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .rx_pixel_clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_vc(in_vc),
    .vc_ena(vc_ena), .out_data(out_data), .out_vc(out_vc), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .ok_cnt(ok_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: packet-level view of the stream.
  bit                m_hunt, m_hold;
  logic [7:0]        q[$];
  logic [1:0]        m_vc, m_out_vc;
  int                m_idle, m_ok, m_err, m_drop;
  logic [DLEN*8-1:0] m_out;

  function automatic int bump(input int c);
    return (c >= 65535) ? c : c + 1;
  endfunction

  task automatic model_reset();
    m_hunt = 1; m_hold = 0; q.delete(); m_vc = 0; m_idle = 0;
    m_out = '0; m_out_vc = 0; m_ok = 0; m_err = 0; m_drop = 0;
  endtask

  task automatic m_start(input logic [1:0] vc);
    m_hunt = 0; q.delete(); m_vc = vc; m_idle = 0;
  endtask

  task automatic model_step(input logic v, input logic [63:0] d, input logic [1:0] vc, input logic rdy);
    bit acc, hdr;
    int s;
    acc = v && vc_ena[vc];
    hdr = (d[BPW*8-1:0] == {BPW{SYNC}});
    if (m_hold) begin
      if (rdy) begin
        m_hold = 0;
        if (acc && hdr) m_start(vc);
        else m_hunt = 1;
      end else if (acc && hdr) m_drop = bump(m_drop);
    end else if (m_hunt) begin
      if (acc && hdr) m_start(vc);
    end else if (acc && vc == m_vc) begin
      m_idle = 0;
      if (q.size() < DLEN) begin
        for (int i = BPW - 1; i >= 0; i--) q.push_back(d[i*8 +: 8]);
      end else begin
        s = 0;
        foreach (q[i]) s += int'(q[i]);
        s = s % 256;
        if (int'(d[BPW*8-1 -: 8]) == s) begin
          m_hold = 1;
          m_out = '0;
          foreach (q[i]) m_out = (m_out << 8) | (DLEN*8)'(q[i]);
          m_out_vc = m_vc;
          m_ok = bump(m_ok);
        end else begin
          m_hunt = 1;
          m_err = bump(m_err);
        end
      end
    end else begin
      m_idle++;
      if (m_idle >= TIMEOUT) begin
        m_hunt = 1;
        m_err = bump(m_err);
      end
    end
  endtask

  task automatic compare_all();
    chk("out_valid", out_valid, m_hold);
    chk("busy", busy, !m_hunt);
    chk("out_data", out_data, m_out);
    chk("out_vc", out_vc, m_out_vc);
    chk("ok_cnt", ok_cnt, m_ok);
    chk("err_cnt", err_cnt, m_err);
    chk("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic step(input logic v, input logic [63:0] d, input logic [1:0] vc, input logic rdy);
    @(negedge clk);
    in_valid = v; in_data = d; in_vc = vc; out_ready = rdy;
    model_step(v, d, vc, rdy);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 64'h0, 2'd0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; out_ready = 0;
    model_reset();
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_data"}, out_data, '0);
    chk({tag, "_vc"}, out_vc, 2'd0);
    chk({tag, "_ok"}, ok_cnt, 16'd0);
    chk({tag, "_err"}, err_cnt, 16'd0);
    chk({tag, "_drop"}, drop_cnt, 16'd0);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Off-channel noise between packet beats.
  task automatic noise(input logic [1:0] vc);
    repeat ($urandom_range(0, 2))
      step(rbit(), {$urandom, $urandom}, vc ^ 2'($urandom_range(1, 3)), rbit());
  endtask

  task automatic send_pkt(input logic [1:0] vc, input bit good, input bit stall);
    logic [63:0] d;
    logic [7:0]  s;
    s = 8'h0;
    d = {$urandom, $urandom};
    d[BPW*8-1:0] = {BPW{SYNC}};
    step(1'b1, d, vc, rbit());
    for (int b = 0; b < NB; b++) begin
      noise(vc);
      if (stall && b == 1) repeat (TIMEOUT + 1) idle(rbit());
      d = {$urandom, $urandom};
      for (int i = 0; i < BPW; i++) s = s + d[i*8 +: 8];
      step(1'b1, d, vc, rbit());
    end
    noise(vc);
    d = {$urandom, $urandom};
    d[BPW*8-1 -: 8] = good ? s : s + 8'($urandom_range(1, 255));
    step(1'b1, d, vc, rbit());
  endtask

  logic [3:0] ena_tbl [4] = '{4'b0001, 4'b0011, 4'b1111, 4'b0101};

  initial begin
    rst = 1; in_valid = 0; in_data = '0; in_vc = 0; vc_ena = 4'b0001; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk_zero("reset");
    @(negedge clk);
    rst = 0;

    // Good packet
    step(1, HDR, 0, 0); step(1, P1, 0, 0); step(1, P2, 0, 0); step(1, TRL_OK, 0, 0);
    chk("good_valid", out_valid, 1'b1);
    chk("good_data", out_data, PAY);
    chk("good_vc", out_vc, 2'd0);
    chk("good_ok", ok_cnt, 16'd1);
    idle(1);
    chk("good_release", out_valid, 1'b0);

    // Bad trailer
    do_reset();
    step(1, HDR, 0, 0); step(1, P1, 0, 0); step(1, P2, 0, 0); step(1, TRL_BAD, 0, 0);
    chk("bad_valid", out_valid, 1'b0);
    chk("bad_err", err_cnt, 16'd1);
    chk("bad_busy", busy, 1'b0);

    // Drop in HOLD, then handshake + header takes the header
    do_reset();
    step(1, HDR, 0, 0); step(1, P1, 0, 0); step(1, P2, 0, 0); step(1, TRL_OK, 0, 0);
    step(1, HDR, 0, 0);
    chk("hold_drop", drop_cnt, 16'd1);
    chk("hold_data", out_data, PAY);
    chk("hold_valid", out_valid, 1'b1);
    step(1, HDR, 0, 1);
    chk("take_valid", out_valid, 1'b0);
    chk("take_busy", busy, 1'b1);
    chk("take_drop", drop_cnt, 16'd1);
    step(1, P2, 0, 0); step(1, P1, 0, 0); step(1, TRL_OK, 0, 0);
    chk("take_ok", ok_cnt, 16'd2);
    chk("take_data", out_data, 96'h0708_090A_0B0C_0102_0304_0506);

    // Timeout boundary
    do_reset();
    step(1, HDR, 0, 0); step(1, P1, 0, 0);
    repeat (TIMEOUT - 1) idle(0);
    chk("tmo_pre_busy", busy, 1'b1);
    chk("tmo_pre_err", err_cnt, 16'd0);
    idle(0);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_err", err_cnt, 16'd1);

    // Disabled VC and interleaved foreign-VC beats
    for (int e = 0; e < 2; e++) begin
      do_reset();
      vc_ena = (e == 0) ? 4'b0001 : 4'b0011;
      if (e == 0) begin
        step(1, HDR, 1, 0);
        chk("vc1_hdr_busy", busy, 1'b0);
      end
      step(1, HDR, 0, 0);
      step(1, 64'h0000_FFEE_DDCC_BBAA, 1, 0);
      step(1, P1, 0, 0);
      step(1, 64'h0000_1111_2222_3333, 1, 0);
      step(1, P2, 0, 0);
      step(1, 64'h0000_9900_0000_0000, 1, 0);
      step(1, TRL_OK, 0, 0);
      chk("ilv_data", out_data, PAY);
      chk("ilv_ok", ok_cnt, 16'd1);
    end
    vc_ena = 4'b0001;

    // Reset mid-packet
    do_reset();
    step(1, HDR, 0, 0); step(1, P1, 0, 0); step(1, P2, 0, 0);
    do_reset();
    chk_zero("midrst");
    step(1, HDR, 0, 0); step(1, P1, 0, 0); step(1, P2, 0, 0); step(1, TRL_OK, 0, 0);
    chk("midrst_ok", ok_cnt, 16'd1);
    chk("midrst_data", out_data, PAY);

    // Randomized traffic
    do_reset();
    for (int p = 0; p < 150; p++) begin
      logic [1:0] vc;
      vc_ena = ena_tbl[$urandom_range(0, 3)];
      do vc = 2'($urandom_range(0, 3)); while (!vc_ena[vc]);
      send_pkt(vc, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 3)) idle(rbit());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
